// File: rtl/sme_host_feeder.sv
// Purpose: buffers one string and up to NPAT patterns from a host, streams them to the matching engine and returns one result per pattern.
// Latency: first character 1 cycle after start; each result 1 cycle after sme_valid.
// Backpressure: none toward the engine; host writes/start/clear are ignored outside IDLE, and a missing engine response times out.
module sme_host_feeder #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    parameter int NPAT    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [7:0] wr_data,
    input  logic       wr_last,
    input  logic       wr_clr,
    input  logic       start,
    input  logic       new_str,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index,
    output logic       busy,
    output logic       res_valid,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic [1:0] res_pid,
    output logic       done,
    output logic       err
);

    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int SAW = $clog2(STR_MAX);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int PCW = $clog2(NPAT + 1);
    localparam int PIW = $clog2(NPAT);
    localparam int TW  = $clog2(TIMEOUT);
    localparam int IW  = (SLW > PLW) ? SLW : PLW;

    localparam logic [SLW-1:0] STR_FULL  = SLW'(STR_MAX);
    localparam logic [PLW-1:0] PAT_FULL  = PLW'(PAT_MAX);
    localparam logic [PCW-1:0] PCNT_FULL = PCW'(NPAT);
    localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_STR,
        S_SEND_PAT,
        S_WAIT_RES,
        S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [SLW-1:0] str_len_q, str_len_d;
    logic [PCW-1:0] pat_cnt_q, pat_cnt_d;
    logic [PLW-1:0] cur_len_q, cur_len_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [PCW-1:0] pid_q, pid_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic           err_q, err_d;
    logic           bad_done_q, bad_done_d;
    logic           res_vld_q, res_vld_d;
    logic           res_match_q, res_match_d;
    logic [4:0]     res_index_q, res_index_d;
    logic [1:0]     res_pid_q, res_pid_d;

    logic [7:0]     str_q [STR_MAX];
    logic [7:0]     pat_q [NPAT][PAT_MAX];
    logic [PLW-1:0] pat_len_q [NPAT];

    logic           ld_ok;
    logic           str_wr;
    logic           str_ovf;
    logic           pat_room;
    logic           pat_wr;
    logic           pat_ovf;
    logic [PLW-1:0] cur_pat_len;
    logic [PCW-1:0] pid_nxt;

    // Host writes are only honoured while idle; clear takes priority over a write in the same cycle.
    assign ld_ok       = reset && (state_q == S_IDLE) && wr_en && !wr_clr;
    assign str_wr      = ld_ok && !wr_sel && (str_len_q != STR_FULL);
    assign str_ovf     = ld_ok && !wr_sel && (str_len_q == STR_FULL);
    assign pat_room    = (pat_cnt_q != PCNT_FULL) && (cur_len_q != PAT_FULL);
    assign pat_wr      = ld_ok && wr_sel && pat_room;
    assign pat_ovf     = ld_ok && wr_sel && !pat_room;
    assign cur_pat_len = pat_len_q[pid_q[PIW-1:0]];
    assign pid_nxt     = pid_q + PCW'(1);

    // Character storage, written only on accepted host writes.
    always_ff @(posedge clk) begin
        if (str_wr) begin
            str_q[str_len_q[SAW-1:0]] <= wr_data;
        end
        if (pat_wr) begin
            pat_q[pat_cnt_q[PIW-1:0]][cur_len_q[PAW-1:0]] <= wr_data;
            if (wr_last) begin
                pat_len_q[pat_cnt_q[PIW-1:0]] <= cur_len_q + PLW'(1);
            end
        end
    end

    // Control and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            str_len_q   <= '0;
            pat_cnt_q   <= '0;
            cur_len_q   <= '0;
            idx_q       <= '0;
            pid_q       <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
            bad_done_q  <= 1'b0;
            res_vld_q   <= 1'b0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
            res_pid_q   <= '0;
        end else begin
            state_q     <= state_d;
            str_len_q   <= str_len_d;
            pat_cnt_q   <= pat_cnt_d;
            cur_len_q   <= cur_len_d;
            idx_q       <= idx_d;
            pid_q       <= pid_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            bad_done_q  <= bad_done_d;
            res_vld_q   <= res_vld_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
            res_pid_q   <= res_pid_d;
        end
    end

    // Next-state logic: loading and job launch in IDLE, then string, patterns and result waits.
    always_comb begin
        state_d     = state_q;
        str_len_d   = str_len_q;
        pat_cnt_d   = pat_cnt_q;
        cur_len_d   = cur_len_q;
        idx_d       = idx_q;
        pid_d       = pid_q;
        tmo_d       = tmo_q;
        err_d       = err_q;
        bad_done_d  = 1'b0;
        res_vld_d   = 1'b0;
        res_match_d = res_match_q;
        res_index_d = res_index_q;
        res_pid_d   = res_pid_q;

        case (state_q)
            S_IDLE: begin
                if (wr_clr) begin
                    str_len_d = '0;
                    pat_cnt_d = '0;
                    cur_len_d = '0;
                    err_d     = 1'b0;
                end
                if (str_wr) begin
                    str_len_d = str_len_q + SLW'(1);
                end
                if (pat_wr) begin
                    if (wr_last) begin
                        pat_cnt_d = pat_cnt_q + PCW'(1);
                        cur_len_d = '0;
                    end else begin
                        cur_len_d = cur_len_q + PLW'(1);
                    end
                end
                if (str_ovf || pat_ovf) begin
                    err_d = 1'b1;
                end
                // Start sees the counts including any write accepted in this same cycle.
                if (start) begin
                    if ((pat_cnt_d == '0) || (new_str && (str_len_d == '0))) begin
                        err_d      = 1'b1;
                        bad_done_d = 1'b1;
                    end else begin
                        idx_d   = '0;
                        pid_d   = '0;
                        state_d = new_str ? S_SEND_STR : S_SEND_PAT;
                    end
                end
            end
            S_SEND_STR: begin
                // The engine leaves string-receive as soon as isstring drops, so patterns follow with no gap.
                if (idx_q == IW'(str_len_q - SLW'(1))) begin
                    idx_d   = '0;
                    state_d = S_SEND_PAT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_SEND_PAT: begin
                if (idx_q == IW'(cur_pat_len - PLW'(1))) begin
                    idx_d   = '0;
                    tmo_d   = '0;
                    state_d = S_WAIT_RES;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_WAIT_RES: begin
                // A response arriving in the final allowed cycle still wins over the timeout.
                if (sme_valid) begin
                    res_vld_d   = 1'b1;
                    res_match_d = sme_match;
                    res_index_d = sme_match_index;
                    res_pid_d   = 2'(pid_q);
                    pid_d       = pid_nxt;
                    state_d     = (pid_nxt < pat_cnt_q) ? S_SEND_PAT : S_FIN;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_FIN: begin
                // String is kept so the next job may reuse the engine's held copy.
                pat_cnt_d = '0;
                cur_len_d = '0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Engine-side character stream; chardata is zero whenever no qualifier is high.
    always_comb begin
        isstring  = 1'b0;
        ispattern = 1'b0;
        chardata  = '0;
        case (state_q)
            S_SEND_STR: begin
                isstring = 1'b1;
                chardata = str_q[idx_q[SAW-1:0]];
            end
            S_SEND_PAT: begin
                ispattern = 1'b1;
                chardata  = pat_q[pid_q[PIW-1:0]][idx_q[PAW-1:0]];
            end
            default: begin
                isstring  = 1'b0;
                ispattern = 1'b0;
                chardata  = '0;
            end
        endcase
    end

    assign busy      = (state_q == S_SEND_STR) || (state_q == S_SEND_PAT) || (state_q == S_WAIT_RES);
    assign done      = (state_q == S_FIN) || bad_done_q;
    assign err       = err_q;
    assign res_valid = res_vld_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;
    assign res_pid   = res_pid_q;

endmodule

// File: tb/tb_sme_host_feeder.sv
// Purpose: randomized and directed checking of sme_host_feeder against a queue-based model of host jobs.
// Latency: expects first character 1 cycle after start and each result 1 cycle after sme_valid.
// Backpressure: host inputs are driven with random noise while busy and must have no effect.
module tb_sme_host_feeder;

    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;
    localparam int NPAT    = 4;
    localparam int TIMEOUT = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en, wr_sel, wr_last, wr_clr, start, new_str;
    logic [7:0] wr_data;
    logic [7:0] chardata;
    logic       isstring, ispattern;
    logic       sme_valid, sme_match;
    logic [4:0] sme_match_index;
    logic       busy, res_valid, res_match, done, err;
    logic [4:0] res_index;
    logic [1:0] res_pid;

    always #5 clk = ~clk;

    sme_host_feeder #(
        .STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX), .NPAT(NPAT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data), .wr_last(wr_last),
        .wr_clr(wr_clr), .start(start), .new_str(new_str),
        .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .busy(busy), .res_valid(res_valid), .res_match(res_match),
        .res_index(res_index), .res_pid(res_pid), .done(done), .err(err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what the host has loaded, as plain queues.
    logic [7:0] m_str[$];
    logic [7:0] m_pat[NPAT][$];
    logic [7:0] m_cur[$];
    int         m_np  = 0;
    logic       m_err = 1'b0;

    // Engine responses per pattern for the next job.
    int         r_wait  [NPAT];
    logic       r_match [NPAT];
    logic [4:0] r_idx   [NPAT];

    // Expected result strobe for the current cycle.
    logic       exp_rv = 1'b0;
    logic       exp_rm;
    logic [4:0] exp_ri;
    logic [1:0] exp_rp;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        wr_en = 0; wr_sel = 0; wr_data = 0; wr_last = 0; wr_clr = 0; start = 0; new_str = 0;
    endtask

    task automatic noise();
        wr_en   = 1'($urandom);
        wr_sel  = 1'($urandom);
        wr_data = 8'($urandom);
        wr_last = 1'($urandom);
        wr_clr  = 1'($urandom);
        start   = 1'($urandom);
        new_str = 1'($urandom);
    endtask

    function automatic void model_clear();
        m_str.delete();
        m_cur.delete();
        for (int p = 0; p < NPAT; p++) m_pat[p].delete();
        m_np  = 0;
        m_err = 1'b0;
    endfunction

    function automatic void model_wr(input logic sel, input logic [7:0] d, input logic last);
        if (!sel) begin
            if (m_str.size() < STR_MAX) m_str.push_back(d);
            else m_err = 1'b1;
        end else if (m_np == NPAT || m_cur.size() == PAT_MAX) begin
            m_err = 1'b1;
        end else begin
            m_cur.push_back(d);
            if (last) begin
                m_pat[m_np] = m_cur;
                m_np++;
                m_cur.delete();
            end
        end
    endfunction

    task automatic do_reset();
        quiet();
        sme_valid = 0; sme_match = 0; sme_match_index = 0;
        reset = 0;
        tick(); tick();
        reset = 1;
        model_clear();
        exp_rv = 1'b0;
    endtask

    task automatic host_wr(input logic sel, input logic [7:0] d, input logic last);
        wr_en = 1; wr_sel = sel; wr_data = d; wr_last = last;
        tick();
        quiet();
        model_wr(sel, d, last);
    endtask

    task automatic host_clr();
        wr_clr = 1;
        tick();
        quiet();
        model_clear();
    endtask

    task automatic load_str_s(input string s);
        for (int i = 0; i < s.len(); i++) host_wr(1'b0, s[i], 1'b0);
    endtask

    task automatic load_pat_s(input string s);
        for (int i = 0; i < s.len(); i++) host_wr(1'b1, s[i], i == s.len() - 1);
    endtask

    // One busy cycle: qualifiers, character, busy, and any result due this cycle.
    task automatic cyc_chk(input string ph, input logic is, input logic ip, input logic [7:0] cd);
        chk({ph, ".isstring"}, isstring, is);
        chk({ph, ".ispattern"}, ispattern, ip);
        chk({ph, ".chardata"}, chardata, cd);
        chk({ph, ".busy"}, busy, 1'b1);
        chk({ph, ".done"}, done, 1'b0);
        chk({ph, ".res_valid"}, res_valid, exp_rv);
        if (exp_rv) begin
            chk({ph, ".res_match"}, res_match, exp_rm);
            chk({ph, ".res_index"}, res_index, exp_ri);
            chk({ph, ".res_pid"}, res_pid, exp_rp);
        end
        exp_rv = 1'b0;
    endtask

    task automatic fin_chk(input string ph);
        chk({ph, ".done"}, done, 1'b1);
        chk({ph, ".busy"}, busy, 1'b0);
        chk({ph, ".isstring"}, isstring, 1'b0);
        chk({ph, ".ispattern"}, ispattern, 1'b0);
        chk({ph, ".chardata"}, chardata, 8'h00);
        chk({ph, ".err"}, err, m_err);
        chk({ph, ".res_valid"}, res_valid, exp_rv);
        if (exp_rv) begin
            chk({ph, ".res_match"}, res_match, exp_rm);
            chk({ph, ".res_index"}, res_index, exp_ri);
            chk({ph, ".res_pid"}, res_pid, exp_rp);
        end
        exp_rv = 1'b0;
        tick();
        chk({ph, ".done_after"}, done, 1'b0);
        chk({ph, ".res_valid_after"}, res_valid, 1'b0);
        m_np = 0;
        m_cur.delete();
    endtask

    // Full job: optional write in the start cycle, then the expected stream cycle by cycle.
    task automatic run_job(input logic ns, input logic tmo_mode, input logic combo, input logic [7:0] cdat);
        if (combo) begin
            wr_en = 1; wr_sel = 1; wr_data = cdat; wr_last = 1;
            model_wr(1'b1, cdat, 1'b1);
        end
        start = 1; new_str = ns;
        tick();
        quiet();
        if (ns) begin
            for (int i = 0; i < m_str.size(); i++) begin
                cyc_chk("str", 1'b1, 1'b0, m_str[i]);
                noise(); sme_valid = 1'($urandom);
                tick();
            end
        end
        for (int p = 0; p < m_np; p++) begin
            for (int j = 0; j < m_pat[p].size(); j++) begin
                cyc_chk("pat", 1'b0, 1'b1, m_pat[p][j]);
                noise(); sme_valid = 1'($urandom);
                tick();
            end
            sme_valid = 0;
            if (tmo_mode) begin
                for (int k = 0; k < TIMEOUT; k++) begin
                    cyc_chk("tmo_wait", 1'b0, 1'b0, 8'h00);
                    noise();
                    tick();
                end
                quiet();
                m_err = 1'b1;
                fin_chk("tmo_fin");
                return;
            end
            for (int k = 0; k < r_wait[p]; k++) begin
                cyc_chk("wait", 1'b0, 1'b0, 8'h00);
                noise();
                tick();
            end
            cyc_chk("wait_vld", 1'b0, 1'b0, 8'h00);
            sme_valid = 1; sme_match = r_match[p]; sme_match_index = r_idx[p];
            noise();
            tick();
            sme_valid = 0;
            exp_rv = 1'b1; exp_rm = r_match[p]; exp_ri = r_idx[p]; exp_rp = 2'(p);
        end
        quiet();
        fin_chk("fin");
    endtask

    task automatic bad_start(input logic ns);
        start = 1; new_str = ns;
        tick();
        quiet();
        m_err = 1'b1;
        chk("bad.done", done, 1'b1);
        chk("bad.busy", busy, 1'b0);
        chk("bad.isstring", isstring, 1'b0);
        chk("bad.ispattern", ispattern, 1'b0);
        chk("bad.chardata", chardata, 8'h00);
        chk("bad.err", err, m_err);
        tick();
        chk("bad.done_after", done, 1'b0);
        chk("bad.busy_after", busy, 1'b0);
    endtask

    initial begin
        do_reset();
        chk("rst.busy", busy, 1'b0);
        chk("rst.done", done, 1'b0);
        chk("rst.err", err, 1'b0);
        chk("rst.isstring", isstring, 1'b0);
        chk("rst.ispattern", ispattern, 1'b0);
        chk("rst.chardata", chardata, 8'h00);
        chk("rst.res_valid", res_valid, 1'b0);
        chk("rst.res_pid", res_pid, 2'd0);

        // Single pattern over a fresh string.
        host_clr();
        load_str_s("hello world");
        load_pat_s("wor");
        r_wait[0] = 3; r_match[0] = 1'b1; r_idx[0] = 5'd6;
        run_job(1'b1, 1'b0, 1'b0, 8'h00);

        // Three patterns against the held string.
        load_pat_s("a");
        load_pat_s("^he");
        load_pat_s("z$");
        for (int p = 0; p < 3; p++) begin
            r_wait[p] = p * 2; r_match[p] = 1'(p); r_idx[p] = 5'(p + 9);
        end
        run_job(1'b0, 1'b0, 1'b0, 8'h00);

        // Engine never answers.
        load_pat_s("x");
        run_job(1'b0, 1'b1, 1'b0, 8'h00);
        host_clr();
        chk("clr.err", err, m_err);

        // String overflow.
        for (int i = 0; i < STR_MAX + 1; i++) host_wr(1'b0, 8'($urandom), 1'b0);
        chk("ovf.str_len", 32'(dut.str_len_q), m_str.size());
        chk("ovf.str_err", err, m_err);
        host_clr();
        bad_start(1'b0);
        host_clr();
        load_pat_s("q");
        bad_start(1'b1);
        for (int i = 0; i < PAT_MAX + 1; i++) host_wr(1'b1, 8'($urandom), 1'b0);
        chk("ovf.pat_len", 32'(dut.cur_len_q), m_cur.size());
        chk("ovf.pat_err", err, m_err);

        // Too many patterns: the extra one is dropped, the rest still transmit.
        do_reset();
        for (int p = 0; p < NPAT + 1; p++) host_wr(1'b1, 8'($urandom), 1'b1);
        chk("npat.err", err, m_err);
        chk("npat.cnt", 32'(dut.pat_cnt_q), m_np);
        for (int p = 0; p < NPAT; p++) begin
            r_wait[p] = 1; r_match[p] = 1'b0; r_idx[p] = 5'(p);
        end
        run_job(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset while the string is being sent.
        host_clr();
        for (int i = 0; i < 10; i++) host_wr(1'b0, 8'($urandom_range(1, 255)), 1'b0);
        load_pat_s("ab");
        start = 1; new_str = 1;
        tick();
        quiet();
        for (int i = 0; i < 5; i++) begin
            cyc_chk("rst_str", 1'b1, 1'b0, m_str[i]);
            tick();
        end
        cyc_chk("rst_str5", 1'b1, 1'b0, m_str[5]);
        reset = 0;
        tick();
        reset = 1;
        model_clear();
        chk("midrst.isstring", isstring, 1'b0);
        chk("midrst.busy", busy, 1'b0);
        chk("midrst.str_len", 32'(dut.str_len_q), m_str.size());
        chk("midrst.pat_cnt", 32'(dut.pat_cnt_q), m_np);
        chk("midrst.done", done, 1'b0);

        // Random jobs.
        for (int it = 0; it < 8; it++) begin
            logic       ns;
            int         np;
            int         plen;
            logic [7:0] last_c;
            ns = (it == 0) ? 1'b1 : 1'($urandom);
            if (ns) begin
                host_clr();
                for (int i = 0, n = $urandom_range(1, STR_MAX); i < n; i++)
                    host_wr(1'b0, 8'($urandom), 1'b0);
            end
            np = $urandom_range(1, NPAT);
            for (int p = 0; p < np; p++) begin
                plen = $urandom_range(1, PAT_MAX);
                for (int j = 0; j < plen; j++) begin
                    if (p == np - 1 && j == plen - 1 && it[0]) begin
                        last_c = 8'($urandom);
                    end else begin
                        host_wr(1'b1, 8'($urandom), j == plen - 1);
                    end
                end
                r_wait[p] = $urandom_range(0, 20);
                r_match[p] = 1'($urandom);
                r_idx[p] = 5'($urandom);
            end
            run_job(ns, 1'b0, it[0], last_c);
            chk("rand.err", err, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sme_host_feeder.md
Name: sme_host_feeder

Overview:
- Host-side transmitter for the string-matching engine interface.
- Buffers one string and up to NPAT patterns written by a host, then serializes them onto chardata/isstring/ispattern.
- Waits for the engine's valid pulse after each pattern and returns one result per pattern (match, index, pattern id) to the host.

Parameters:
- STR_MAX, 32, maximum string length in characters.
- PAT_MAX, 8, maximum pattern length in characters.
- NPAT, 4, maximum patterns per job.
- TIMEOUT, 255, maximum cycles to wait for engine valid per pattern.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-low reset.
- wr_en  in  1  host write strobe; ignored while busy=1.
- wr_sel  in  1  0 = string character, 1 = pattern character.
- wr_data  in  8  character to buffer.
- wr_last  in  1  with wr_en and wr_sel=1: closes the current pattern.
- wr_clr  in  1  clears string length, pattern count and error; ignored while busy.
- start  in  1  begin job; ignored while busy.
- new_str  in  1  sampled with start: 1 = transmit string, 0 = reuse engine's held string.
- chardata  out  8  character to engine.
- isstring  out  1  string character qualifier.
- ispattern  out  1  pattern character qualifier.
- sme_valid  in  1  engine result strobe.
- sme_match  in  1  engine match flag.
- sme_match_index  in  5  engine match index.
- busy  out  1  job in progress.
- res_valid  out  1  one-cycle result strobe.
- res_match  out  1  captured match.
- res_index  out  5  captured index.
- res_pid  out  2  pattern number, 0-based.
- done  out  1  one-cycle end-of-job pulse.
- err  out  1  sticky error flag; cleared by wr_clr or reset.

Behaviour:
- Reset (reset=0 at a clock edge):
  - all outputs 0; str_len=0, pat_cnt=0, cur_len=0, state IDLE.
  - Applies mid-job: the job is abandoned and outputs drop in the next cycle.
- Loading (IDLE only):
  - String write stores at str_len and increments it.
  - A write when str_len=STR_MAX is dropped and sets err.
  - Pattern write stores at pat[pat_cnt][cur_len]. When wr_last=1, pattern length = cur_len+1, pat_cnt increments and cur_len clears.
  - A write when cur_len=PAT_MAX, or when pat_cnt=NPAT, is dropped and sets err.
- start in IDLE:
  - With pat_cnt=0, or with new_str=1 and str_len=0: set err, pulse done the next cycle, send nothing.
  - Otherwise busy=1 from the next cycle and go to SEND_STR (new_str=1) or SEND_PAT (new_str=0).
- SEND_STR:
  - One character per cycle, isstring=1, chardata=str[i], i=0..str_len-1, no gaps.
  - The cycle after the last string character is always the first pattern character (engine leaves string-receive the moment isstring drops).
- SEND_PAT: one character per cycle, ispattern=1, chardata=pat[p][j], contiguous. Then go to WAIT_RES with ispattern=0, chardata=0.
- WAIT_RES:
  - Count cycles. On sme_valid=1, register res_match=sme_match, res_index=sme_match_index, res_pid=p, and pulse res_valid one cycle later.
  - Then p++: if p<pat_cnt, the next pattern starts the cycle after sme_valid was seen; else go to FIN.
  - If the count reaches TIMEOUT: set err, go to FIN, emit no result for that pattern.
- FIN: done=1 for one cycle, busy=0, pat_cnt and cur_len cleared, str_len kept (allows a new_str=0 rerun), back to IDLE.
- isstring and ispattern are never high together. Both are 0 in IDLE, WAIT_RES and FIN. chardata=0 whenever neither is high.
- sme_valid outside WAIT_RES is ignored.
- Simultaneous wr_en and start in IDLE: the write is performed and start uses the updated counts.
- Latency: first character appears 1 cycle after start. Result appears 1 cycle after sme_valid.

Test Plan:
- Load "hello world" (11 chars) and pattern "wor"; start with new_str=1.
  - Required: isstring=1 for exactly 11 cycles, then ispattern=1 for exactly 3 cycles ('w','o','r'), busy=1 throughout.
  - Engine model valid with match=1, index=6 gives res_valid with res_match=1, res_index=6, res_pid=0, then done.
- Load 3 patterns "a", "^he", "z$"; start with new_str=0.
  - Required: no isstring; three pattern bursts of 1, 3 and 2 cycles, each starting the cycle after the prior sme_valid.
  - Results come back with res_pid 0, 1, 2 in order.
- Engine model never asserts valid.
  - Required: after 255 cycles in WAIT_RES, err=1, done pulses, no res_valid; wr_clr then clears err.
- Overflow: 33 string writes give str_len=32 and err=1. 9 writes to one pattern give err=1 and length 8. start with pat_cnt=0 gives done with no chardata activity.
- reset=0 during SEND_STR at character 5: the next cycle shows isstring=0, busy=0, str_len=0, state IDLE. start and wr_en issued while busy have no effect.
